// File: rtl/mult3_sched_pkg.sv
// Shared types and constants for the round-robin mult3 scheduler.
package mult3_sched_pkg;

  localparam int OPW = 3;
  localparam int PW  = 6;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Settle counter holds SETTLE-1 at most; keep at least one bit.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // The last candidate examined is ptr itself, so a lone requester still wins.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult3_sched.sv
// Round-robin scheduler sharing one external 3x3 multiplier between NREQ
// requesters; holds operands for SETTLE cycles, then samples the product.
module mult3_sched
  import mult3_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [OPW*NREQ-1:0] a_in,
  input  logic [OPW*NREQ-1:0] b_in,
  output logic [NREQ-1:0]     gnt,
  output logic [PW-1:0]       result,
  output logic                busy,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic [PW-1:0]       mul_p
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [OPW-1:0] a_arr [NREQ];
  logic [OPW-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = a_in[g*OPW +: OPW];
    assign b_arr[g] = b_in[g*OPW +: OPW];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .grant(pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      ptr    <= IW'(NREQ - 1);
      win    <= '0;
      win_oh <= '0;
      cnt    <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            mul_a  <= a_arr[pick_idx];
            mul_b  <= b_arr[pick_idx];
            win    <= pick_idx;
            win_oh <= pick_oh;
            cnt    <= CNT_LOAD;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        // Multiplier inputs stay frozen while the gate-delay datapath settles.
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            result <= mul_p;
            gnt    <= win_oh;
            state  <= DONE;
          end
        end
        DONE: begin
          ptr   <= win;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult3_sched.sv
// Self-checking bench for mult3_sched with a delayed mult3 behavioural model.
module tb_mult3_sched;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;

  typedef struct {
    int         idx;
    logic [5:0] prod;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [11:0]     a_in;
  logic [11:0]     b_in;
  logic [NREQ-1:0] gnt;
  logic [5:0]      result;
  logic            busy;
  logic [2:0]      mul_a;
  logic [2:0]      mul_b;
  logic [5:0]      mul_p;

  logic [1:0] req2;
  logic [5:0] a2;
  logic [5:0] b2;
  logic [1:0] gnt2;
  logic [5:0] result2;
  logic       busy2;
  logic [2:0] mula2;
  logic [2:0] mulb2;
  logic [5:0] mulp2;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // mult3 stand-in: product appears a few gate delays after the inputs move.
  always @(mul_a, mul_b) mul_p <= #3 mul_a * mul_b;
  always @(mula2, mulb2) mulp2 <= #3 mula2 * mulb2;

  mult3_sched #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .result(result), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  mult3_sched #(.NREQ(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .a_in(a2), .b_in(b2),
    .gnt(gnt2), .result(result2), .busy(busy2),
    .mul_a(mula2), .mul_b(mulb2), .mul_p(mulp2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    req2 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [2:0] a, input logic [2:0] b);
    a_in[3*i +: 3] = a;
    b_in[3*i +: 3] = b;
  endtask

  task automatic wait_gnt(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      step();
      cycles++;
      if (gnt != '0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b, required 0000", gnt); end
    n_tests++;
    if (result !== 6'd0) begin n_fail++; $display("FAIL reset_result: got %0d, required 0", result); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_tests++;
    if (mul_a !== 3'd0 || mul_b !== 3'd0) begin
      n_fail++; $display("FAIL reset_mul: got a=%0d b=%0d, required 0 0", mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    int   cyc;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    do_reset();
    set_op(0, 3'd5, 3'd7);
    req[0] = 1'b1;
    sbq.push_back('{0, 6'd35});
    step();
    cyc      = 1;
    busy_cnt = busy ? 1 : 0;
    n_tests++;
    if (mul_a !== 3'd5 || mul_b !== 3'd7) begin
      n_fail++; $display("FAIL single_operands: got a=%0d b=%0d, required 5 7", mul_a, mul_b);
    end
    seen = (gnt != '0);
    while (!seen && cyc < 20) begin
      step();
      cyc++;
      if (busy) busy_cnt++;
      seen = (gnt != '0);
    end
    e = sbq.pop_front();
    n_tests++;
    if (!seen || cyc != SETTLE + 1) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles (seen=%0b), required %0d", cyc, seen, SETTLE + 1);
    end
    n_tests++;
    if (gnt !== 4'(1 << e.idx) || result !== e.prod) begin
      n_fail++; $display("FAIL single_grant: got gnt=%b result=%0d, required gnt=%b result=%0d",
                         gnt, result, 4'(1 << e.idx), e.prod);
    end
    n_tests++;
    if (busy_cnt != SETTLE + 1) begin
      n_fail++; $display("FAIL single_busy_len: got %0d, required %0d", busy_cnt, SETTLE + 1);
    end
    req[0] = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || result !== 6'd35) begin
      n_fail++; $display("FAIL single_after: got busy=%b gnt=%b result=%0d, required 0 0000 35", busy, gnt, result);
    end
  endtask

  task automatic test_all_four();
    int   cyc;
    bit   seen;
    exp_t e;
    do_reset();
    set_op(0, 3'd1, 3'd2);
    set_op(1, 3'd3, 3'd3);
    set_op(2, 3'd7, 3'd7);
    set_op(3, 3'd6, 3'd5);
    sbq.push_back('{0, 6'd2});
    sbq.push_back('{1, 6'd9});
    sbq.push_back('{2, 6'd49});
    sbq.push_back('{3, 6'd30});
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(20, cyc, seen);
      n_tests++;
      if (!seen) begin
        n_fail++; $display("FAIL all4_timeout: no gnt for grant %0d, required one", k);
        sbq.delete();
        break;
      end
      e = sbq.pop_front();
      if (gnt !== 4'(1 << e.idx) || result !== e.prod) begin
        n_fail++; $display("FAIL all4_grant%0d: got gnt=%b result=%0d, required gnt=%b result=%0d",
                           k, gnt, result, 4'(1 << e.idx), e.prod);
      end
      n_tests++;
      if (cyc != ((k == 0) ? SETTLE + 1 : SETTLE + 2)) begin
        n_fail++; $display("FAIL all4_spacing%0d: got %0d cycles, required %0d",
                           k, cyc, (k == 0) ? SETTLE + 1 : SETTLE + 2);
      end
      req = req & ~gnt;
    end
    req = '0;
    step();
  endtask

  task automatic test_fairness();
    int   cyc;
    bit   seen;
    exp_t e;
    do_reset();
    set_op(0, 3'd2, 3'd3);
    set_op(1, 3'd6, 3'd6);
    set_op(2, 3'd4, 3'd5);
    sbq.push_back('{0, 6'd6});
    sbq.push_back('{2, 6'd20});
    sbq.push_back('{0, 6'd6});
    sbq.push_back('{1, 6'd36});
    sbq.push_back('{2, 6'd20});
    sbq.push_back('{0, 6'd6});
    req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(20, cyc, seen);
      n_tests++;
      if (!seen) begin
        n_fail++; $display("FAIL fair_timeout: no gnt for grant %0d, required one", k);
        sbq.delete();
        break;
      end
      e = sbq.pop_front();
      if (gnt !== 4'(1 << e.idx) || result !== e.prod) begin
        n_fail++; $display("FAIL fair_grant%0d: got gnt=%b result=%0d, required gnt=%b result=%0d",
                           k, gnt, result, 4'(1 << e.idx), e.prod);
      end
      if (k == 2) req[1] = 1'b1;
      if (gnt[1]) req[1] = 1'b0;
    end
    req = '0;
    step();
  endtask

  task automatic test_operand_change();
    int   cyc;
    bit   seen;
    exp_t e;
    do_reset();
    set_op(1, 3'd4, 3'd3);
    req[1] = 1'b1;
    sbq.push_back('{1, 6'd12});
    step();
    set_op(1, 3'd7, 3'd7);
    req[1] = 1'b0;
    n_tests++;
    if (mul_a !== 3'd4 || mul_b !== 3'd3) begin
      n_fail++; $display("FAIL opchg_wait1: got a=%0d b=%0d, required 4 3", mul_a, mul_b);
    end
    step();
    n_tests++;
    if (mul_a !== 3'd4 || mul_b !== 3'd3) begin
      n_fail++; $display("FAIL opchg_wait2: got a=%0d b=%0d, required 4 3", mul_a, mul_b);
    end
    wait_gnt(10, cyc, seen);
    e = sbq.pop_front();
    n_tests++;
    if (!seen || gnt !== 4'(1 << e.idx) || result !== e.prod) begin
      n_fail++; $display("FAIL opchg_result: got seen=%0b gnt=%b result=%0d, required gnt=%b result=%0d",
                         seen, gnt, result, 4'(1 << e.idx), e.prod);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int   cyc;
    bit   seen;
    exp_t e;
    set_op(0, 3'd3, 3'd3);
    req[0] = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got gnt=%b busy=%b, required 0000 0", gnt, busy);
    end
    n_tests++;
    if (result !== 6'd0 || mul_a !== 3'd0 || mul_b !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_data: got result=%0d a=%0d b=%0d, required 0 0 0", result, mul_a, mul_b);
    end
    rst = 1'b0;
    sbq.push_back('{0, 6'd9});
    wait_gnt(20, cyc, seen);
    e = sbq.pop_front();
    n_tests++;
    if (!seen || cyc != SETTLE + 1 || gnt !== 4'(1 << e.idx) || result !== e.prod) begin
      n_fail++; $display("FAIL rstmid_retry: got seen=%0b cyc=%0d gnt=%b result=%0d, required cyc=%0d gnt=%b result=%0d",
                         seen, cyc, gnt, result, SETTLE + 1, 4'(1 << e.idx), e.prod);
    end
    req = '0;
    step();
  endtask

  task automatic test_exhaustive();
    int   cyc;
    bit   seen;
    exp_t e;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        set_op(3, 3'(a), 3'(b));
        req[3] = 1'b1;
        sbq.push_back('{3, 6'(a * b)});
        wait_gnt(20, cyc, seen);
        e = sbq.pop_front();
        n_tests++;
        if (!seen || gnt !== 4'(1 << e.idx) || result !== e.prod) begin
          n_fail++; $display("FAIL exh_%0dx%0d: got seen=%0b gnt=%b result=%0d, required gnt=%b result=%0d",
                             a, b, seen, gnt, result, 4'(1 << e.idx), e.prod);
        end
        req[3] = 1'b0;
      end
    end
    step();
  endtask

  task automatic test_settle1();
    int          cyc;
    logic [2:0]  av [3];
    logic [2:0]  bv [3];
    exp_t        e;
    av = '{3'd6, 3'd7, 3'd0};
    bv = '{3'd7, 3'd7, 3'd5};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a2[5:3] = av[k];
      b2[5:3] = bv[k];
      req2[1] = 1'b1;
      sbq.push_back('{1, 6'(av[k] * bv[k])});
      cyc = 0;
      while (gnt2 == 2'b00 && cyc < 20) begin
        step();
        cyc++;
      end
      e = sbq.pop_front();
      n_tests++;
      if (cyc != 2 || gnt2 !== 2'(1 << e.idx) || result2 !== e.prod) begin
        n_fail++; $display("FAIL settle1_op%0d: got cyc=%0d gnt=%b result=%0d, required cyc=2 gnt=%b result=%0d",
                           k, cyc, gnt2, result2, 2'(1 << e.idx), e.prod);
      end
      req2[1] = 1'b0;
      step();
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    req2 = '0;
    a2   = '0;
    b2   = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_operand_change();
    test_reset_mid();
    test_exhaustive();
    test_settle1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
